kb_event_ctrl: RTL and testbench
================================

Name: kb_event_ctrl

Overview:
- Sequences the raw PS/2 scan-code byte stream from the keyboard receiver into clean key press/release events for the game logic.
- Tracks E0/F0 prefixes and keeps a held-key bitmap for the four arrow lanes plus Enter and Esc.
- Suppresses typematic repeats and buffers events in a small FIFO behind a valid/ready handshake.
- Sits between the PS/2 byte receiver and the StepMania judge/menu logic.

Parameters:
- DEPTH, 4, event FIFO depth in entries; power of two, at least 2.
- TIMEOUT_CYC, 100000, Clk cycles allowed between a prefix byte and its follow-up byte (2 ms at 50 MHz).

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe; scan byte available on byte_in.
- byte_in  in  8  received scan-code byte (set 2).
- byte_err  in  1  one-cycle strobe; framing/parity error on the current byte.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_code  out  3  head event key: 0=Left, 1=Down, 2=Up, 3=Right, 4=Enter, 5=Esc.
- evt_press  out  1  head event type: 1=press, 0=release.
- held  out  6  current held bitmap, indexed by evt_code.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- clr_err  in  1  clears overflow.

Behaviour:
- Async reset (reset_n=0): state=IDLE, held=0, FIFO empty, evt_valid=0, overflow=0, timeout counter=0. Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK. The FSM advances only on byte_valid=1 with byte_err=0.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - 5A -> make Enter; 76 -> make Esc.
  - Any other byte (including AA, FA, EE, FE, E1) -> ignored. Stay in IDLE.
- EXT:
  - F0 -> EXT_BRK; E0 -> stay in EXT.
  - 6B/72/75/74 -> make Left/Down/Up/Right, then IDLE.
  - Any other byte -> IDLE, no event.
- BRK: 5A/76 -> break Enter/Esc; anything else is ignored. Return to IDLE.
- EXT_BRK: 6B/72/75/74 -> break of the matching lane; anything else is ignored. Return to IDLE.
- byte_err=1 forces IDLE from any state. No event, held unchanged.
- Timeout:
  - Counter clears on every accepted byte and increments each cycle while state != IDLE.
  - When it reaches TIMEOUT_CYC-1 the FSM returns to IDLE. No event is generated.
  - Counter width is $clog2(TIMEOUT_CYC).
- Make of key k:
  - held[k]=0: set held[k] and push {press=1, k}.
  - held[k]=1: typematic repeat, no push.
- Break of key k:
  - held[k]=1: clear held[k] and push {press=0, k}.
  - held[k]=0: no push.
- held is updated even when the push is dropped.
- Latency: decode, held update and push are registered on the byte_valid cycle. evt_valid rises in the next cycle when the FIFO was empty.
- Handshake:
  - Pop occurs when evt_valid && evt_ready.
  - evt_code/evt_press stay stable while evt_valid=1 and evt_ready=0.
- FIFO full with a push and no pop: event dropped, overflow=1.
- FIFO full with a push and a pop in the same cycle: both occur, no overflow.
- FIFO empty: evt_ready is ignored.
- Read/write pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- clr_err and a new overflow in the same cycle: overflow=1 (set wins).

Decomposition:
- Package kb_pkg holds:
  - state enum kb_state_t;
  - scan constants SC_EXT=E0, SC_BRK=F0, SC_LEFT=6B, SC_DOWN=72, SC_UP=75, SC_RIGHT=74, SC_ENTER=5A, SC_ESC=76;
  - event code constants EV_LEFT..EV_ESC;
  - event struct kb_evt_t {press, code[2:0]}.
- One sub-module, kb_evt_fifo: a synchronous FIFO of kb_evt_t with push/pop/full/empty. It uses the same Clk and reset_n.

Test Plan:
- Bytes E0,75 with evt_ready=1 -> one event {press=1, code=2}; held=6'b000100. Then E0,F0,75 -> {press=0, code=2}; held=0.
- Bytes 5A,5A,5A (typematic) then F0,5A -> exactly two events: {1,4} then {0,4}.
- evt_ready=0, then 5 distinct makes (6B,72,75,74 extended, plus 5A) -> first 4 events queued in order; 5th dropped; overflow=1; held=6'b011111. clr_err then clears overflow.
- FIFO full with evt_ready=1 while a new make arrives in the same cycle -> push accepted, FIFO count stays 4, overflow=0.
- Byte E0 followed by TIMEOUT_CYC idle cycles, then byte 75 -> no event; FSM back in IDLE. Next byte 5A -> Enter make.
- byte_err during EXT_BRK after E0,F0 -> no event, held unchanged. reset_n=0 mid-sequence (after F0) -> outputs zero immediately; next byte 76 -> Esc make.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard event controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, set-2 scan constants, event codes, event struct,
//           and scan-byte decode helpers.
package kb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  // Set-2 scan codes of interest
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Event codes double as the bit index into the held bitmap
  localparam logic [2:0] EV_LEFT  = 3'd0;
  localparam logic [2:0] EV_DOWN  = 3'd1;
  localparam logic [2:0] EV_UP    = 3'd2;
  localparam logic [2:0] EV_RIGHT = 3'd3;
  localparam logic [2:0] EV_ENTER = 3'd4;
  localparam logic [2:0] EV_ESC   = 3'd5;

  typedef struct packed {
    logic       press;
    logic [2:0] code;
  } kb_evt_t;

  // Arrow lanes only arrive behind an E0 prefix. Returns {hit, code}.
  function automatic logic [3:0] lane_decode(input logic [7:0] b);
    case (b)
      SC_LEFT:  return {1'b1, EV_LEFT};
      SC_DOWN:  return {1'b1, EV_DOWN};
      SC_UP:    return {1'b1, EV_UP};
      SC_RIGHT: return {1'b1, EV_RIGHT};
      default:  return 4'b0000;
    endcase
  endfunction

  // Enter/Esc are unprefixed keys. Returns {hit, code}.
  function automatic logic [3:0] sys_decode(input logic [7:0] b);
    case (b)
      SC_ENTER: return {1'b1, EV_ENTER};
      SC_ESC:   return {1'b1, EV_ESC};
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/kb_evt_fifo.sv
// Synchronous FIFO of kb_evt_t entries; head entry is presented combinationally.
// Latency: an entry pushed on an edge is visible at the head after that edge.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
// Ports: Clk/reset_n; push_i + push_dat_i write; pop_i removes head (ignored
//        when empty); head_dat_o is the oldest entry; full_o / empty_o status.
module kb_evt_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    Clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  kb_evt_t push_dat_i,
  input  logic    pop_i,
  output kb_evt_t head_dat_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  kb_evt_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNTW'(DEPTH));
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so full+push+pop is accepted.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/kb_event_ctrl.sv
// Turns the PS/2 set-2 scan byte stream into key press/release events for six keys.
// Latency: event registered on the byte_valid edge; evt_valid rises next cycle if FIFO empty.
// Backpressure: valid/ready on evt_*; events arriving at a full FIFO are dropped, overflow set.
// Ports: Clk, reset_n; byte_valid/byte_in/byte_err from the PS/2 receiver;
//        evt_valid/evt_ready/evt_code/evt_press event stream; held bitmap;
//        overflow sticky flag cleared by clr_err.
module kb_event_ctrl
  import kb_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       byte_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       evt_press,
  output logic [5:0] held,
  output logic       overflow,
  input  logic       clr_err
);

  localparam int             CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

  kb_state_t     state_q, state_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [5:0]    held_q, held_d;
  logic          ovf_q, ovf_d;

  logic          byte_ok, to_hit;
  logic [3:0]    lane_hit, sys_hit;
  logic          dec_vld, dec_make;
  logic [2:0]    dec_code;
  logic          push;
  kb_evt_t       push_dat, head_dat;
  logic          fifo_full, fifo_empty, pop;

  assign byte_ok  = byte_valid && !byte_err;
  assign to_hit   = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);
  assign lane_hit = lane_decode(byte_in);
  assign sys_hit  = sys_decode(byte_in);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // An accepted byte takes priority over a timeout expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    if (byte_valid && byte_err) begin
      state_d = ST_IDLE;
    end else if (byte_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_in == SC_EXT)      state_d = ST_EXT;
          else if (byte_in == SC_BRK) state_d = ST_BRK;
        end
        ST_EXT: begin
          if (byte_in == SC_BRK)      state_d = ST_EXT_BRK;
          else if (byte_in == SC_EXT) state_d = ST_EXT;
          else                        state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_hit) begin
      state_d = ST_IDLE;
    end
    // The counter only runs while a prefix is pending and restarts on any byte.
    to_cnt_d = (byte_valid || state_d == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
  end

  // ---------------- FSM: outputs (key decode) ----------------
  always_comb begin
    dec_vld  = 1'b0;
    dec_make = 1'b0;
    dec_code = EV_LEFT;
    if (byte_ok) begin
      case (state_q)
        ST_IDLE: begin
          dec_vld  = sys_hit[3];
          dec_make = 1'b1;
          dec_code = sys_hit[2:0];
        end
        ST_EXT: begin
          dec_vld  = lane_hit[3];
          dec_make = 1'b1;
          dec_code = lane_hit[2:0];
        end
        ST_BRK: begin
          dec_vld  = sys_hit[3];
          dec_code = sys_hit[2:0];
        end
        default: begin
          dec_vld  = lane_hit[3];
          dec_code = lane_hit[2:0];
        end
      endcase
    end
  end

  // A make on a held key is typematic repeat; a break on a released key is
  // spurious. Either way the bitmap already matches, so nothing is pushed.
  assign push           = dec_vld && (dec_make != held_q[dec_code]);
  assign push_dat.press = dec_make;
  assign push_dat.code  = dec_code;
  assign pop            = evt_ready && !fifo_empty;

  always_comb begin
    held_d = held_q;
    if (push) held_d[dec_code] = dec_make;
    // Set beats clear when both happen in one cycle.
    ovf_d = (ovf_q && !clr_err) || (push && fifo_full && !pop);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end

  kb_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_dat.code;
  assign evt_press = head_dat.press;
  assign held      = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Directed bench for kb_event_ctrl with hand-computed expected events.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_kb_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_err;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic       evt_press;
  logic [5:0] held;
  logic       overflow;
  logic       clr_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  kb_event_ctrl #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_err   (byte_err),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_press  (evt_press),
    .held       (held),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic send_byte(input logic [7:0] b, input logic err);
    byte_in    = b;
    byte_err   = err;
    byte_valid = 1'b1;
    @(negedge Clk);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Bounded wait for the head event, check it, then pop it.
  task automatic expect_evt(input string tag, input int code, input int press);
    int waited;
    waited = 0;
    while (!evt_valid && waited < 8) begin
      @(negedge Clk);
      waited++;
    end
    check_eq({tag, ".vld"}, int'(evt_valid), 1);
    check_eq({tag, ".code"}, int'(evt_code), code);
    check_eq({tag, ".press"}, int'(evt_press), press);
    evt_ready = 1'b1;
    @(negedge Clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    byte_err   = 1'b0;
    evt_ready  = 1'b0;
    clr_err    = 1'b0;
    idle(3);
    check_eq("rst.vld", int'(evt_valid), 0);
    check_eq("rst.held", int'(held), 0);
    check_eq("rst.ovf", int'(overflow), 0);
    check_eq("rst.code", int'(evt_code), 0);
    check_eq("rst.press", int'(evt_press), 0);
    reset_n = 1'b1;
    idle(2);

    // Extended make / break of Up, with one-cycle latency check
    send_byte(8'hE0, 1'b0);
    check_eq("up_mk.early", int'(evt_valid), 0);
    send_byte(8'h75, 1'b0);
    check_eq("up_mk.lat", int'(evt_valid), 1);
    check_eq("up_mk.held", int'(held), 6'b000100);
    expect_evt("up_mk", 2, 1);
    check_eq("up_mk.drained", int'(evt_valid), 0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_eq("up_brk.held", int'(held), 0);
    expect_evt("up_brk", 2, 0);

    // Ignored bytes in IDLE, then typematic Enter
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    send_byte(8'hE1, 1'b0);
    idle(1);
    check_eq("ign.vld", int'(evt_valid), 0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_eq("typ.held", int'(held), 6'b010000);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
    expect_evt("typ.mk", 4, 1);
    expect_evt("typ.brk", 4, 0);
    check_eq("typ.only2", int'(evt_valid), 0);

    // Fill the FIFO, fifth event dropped
    send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    check_eq("fill.ovf_pre", int'(overflow), 0);
    send_byte(8'h5A, 1'b0);
    check_eq("fill.ovf", int'(overflow), 1);
    check_eq("fill.held", int'(held), 6'b011111);
    check_eq("fill.head_stable", int'(evt_code), 0);
    clr_err = 1'b1;
    @(negedge Clk);
    clr_err = 1'b0;
    check_eq("clr.ovf", int'(overflow), 0);

    // Full FIFO: push of Esc make coincides with pop of Left
    check_eq("fullpop.head", int'(evt_code), 0);
    evt_ready = 1'b1;
    send_byte(8'h76, 1'b0);
    evt_ready = 1'b0;
    check_eq("fullpop.ovf", int'(overflow), 0);
    check_eq("fullpop.held", int'(held), 6'b111111);
    expect_evt("fp.d", 1, 1);
    expect_evt("fp.u", 2, 1);
    expect_evt("fp.r", 3, 1);
    expect_evt("fp.esc", 5, 1);
    check_eq("fp.count4", int'(evt_valid), 0);

    // Fill with lane breaks; drop coincides with clr_err, set wins
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h6B, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h72, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h74, 1'b0);
    send_byte(8'hF0, 1'b0);
    clr_err = 1'b1;
    send_byte(8'h5A, 1'b0);
    clr_err = 1'b0;
    check_eq("setwin.ovf", int'(overflow), 1);
    check_eq("setwin.held", int'(held), 6'b100000);
    clr_err = 1'b1;
    @(negedge Clk);
    clr_err = 1'b0;
    expect_evt("br.l", 0, 0);
    expect_evt("br.d", 1, 0);
    expect_evt("br.u", 2, 0);
    expect_evt("br.r", 3, 0);
    check_eq("br.empty", int'(evt_valid), 0);

    // Prefix within the timeout window still completes
    send_byte(8'hE0, 1'b0);
    idle(TO - 2);
    send_byte(8'h75, 1'b0);
    expect_evt("to.within", 2, 1);
    // Prefix abandoned after TIMEOUT_CYC idle cycles
    send_byte(8'hE0, 1'b0);
    idle(TO);
    send_byte(8'h72, 1'b0);
    idle(2);
    check_eq("to.noevt", int'(evt_valid), 0);
    check_eq("to.held", int'(held), 6'b100100);
    send_byte(8'h5A, 1'b0);
    expect_evt("to.enter", 4, 1);

    // Error byte inside EXT_BRK aborts the break
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b1);
    send_byte(8'h75, 1'b0);
    idle(2);
    check_eq("err.noevt", int'(evt_valid), 0);
    check_eq("err.held", int'(held), 6'b110100);

    // Reset mid-sequence with an event pending
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'hF0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("mrst.vld", int'(evt_valid), 0);
    check_eq("mrst.held", int'(held), 0);
    check_eq("mrst.ovf", int'(overflow), 0);
    @(negedge Clk);
    reset_n = 1'b1;
    idle(1);
    send_byte(8'h76, 1'b0);
    check_eq("mrst.esc_held", int'(held), 6'b100000);
    expect_evt("mrst.esc", 5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
